// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver (1 start, 8 data LSB first, 1 stop, no parity).
// The raw line is brought into the clock domain through a two-flop
// synchroniser. The start bit is re-checked at its centre, and each data and
// stop bit is sampled at its centre. Every received byte is reported with a
// one-cycle rx_valid strobe. A low stop bit gives a single frame_err strobe,
// and the receiver then waits for the line to return high before it hunts for
// the next start bit, so a held-low line (break) cannot produce a stream of
// bogus frames.
// CLKS_PER_BIT must be at least 4 so that the half-bit delay is non-zero.

module uart_rx #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);

    // The last-count values are computed once at full width and then sliced
    // to the counter width.
    localparam logic [31:0] HALF_LAST_W = 32'(HALF - 1);
    localparam logic [31:0] BIT_LAST_W  = 32'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = HALF_LAST_W[CW-1:0];
    localparam logic [CW-1:0] BIT_LAST  = BIT_LAST_W[CW-1:0];

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t        state;
    logic          s1;
    logic          rx_sync;
    logic [CW-1:0] clk_count;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    // Two-flop synchroniser. Both flops reset high so that reset is never
    // mistaken for the falling edge of a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1      <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            s1      <= rx_in;
            rx_sync <= s1;
        end
    end

    // Receive FSM. It owns the bit timing, the shift register and every
    // registered output. The strobes default low, so each pulse lasts exactly
    // the one cycle after the edge that raised it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            clk_count <= '0;
            bit_idx   <= 3'd0;
            shift     <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            rx_busy   <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    clk_count <= '0;
                    bit_idx   <= 3'd0;
                    if (!rx_sync) begin
                        state   <= S_START;
                        rx_busy <= 1'b1;
                    end
                end

                S_START: begin
                    if (clk_count == HALF_LAST) begin
                        clk_count <= '0;
                        if (!rx_sync) begin
                            state   <= S_DATA;
                            bit_idx <= 3'd0;
                        end else begin
                            state   <= S_IDLE;
                            rx_busy <= 1'b0;
                        end
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end

                S_DATA: begin
                    if (clk_count == BIT_LAST) begin
                        clk_count <= '0;
                        shift     <= {rx_sync, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state   <= S_STOP;
                            bit_idx <= 3'd0;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end

                S_STOP: begin
                    if (clk_count == BIT_LAST) begin
                        clk_count <= '0;
                        if (rx_sync) begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                            state    <= S_IDLE;
                            rx_busy  <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_BREAK;
                        end
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end

                S_BREAK: begin
                    clk_count <= '0;
                    if (rx_sync) begin
                        state   <= S_IDLE;
                        rx_busy <= 1'b0;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    clk_count <= '0;
                    bit_idx   <= 3'd0;
                    rx_busy   <= 1'b0;
                end
            endcase
        end
    end

    // A good frame and a framing error are mutually exclusive outcomes.
    assert property (@(posedge clk) disable iff (!rst_n) !(rx_valid && frame_err));

    // rx_busy is a registered copy of "not idle" and must never drift from it.
    assert property (@(posedge clk) disable iff (!rst_n) rx_busy == (state != S_IDLE));

endmodule
